// File: rtl/ttrig_pkg.sv
// rtl/ttrig_pkg.sv - shared state encoding and default widths for the T-trigger bank sequencer
package ttrig_pkg;

  localparam int N_DEF     = 8;
  localparam int CNT_W_DEF = 8;
  localparam int GAP_W_DEF = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/ttrig_cell.sv
// rtl/ttrig_cell.sv - single T flip-flop with clock enable and async active-high reset
module ttrig_cell (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic q,
  output logic nq
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= 1'b0;
    end else if (en) begin
      q <= ~q;
    end
  end

  assign nq = ~q;

endmodule

// File: rtl/ttrig_bank_seq.sv
// rtl/ttrig_bank_seq.sv - command-driven toggle-strobe sequencer in front of a bank of T flip-flops
module ttrig_bank_seq
  import ttrig_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int GAP_W = GAP_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [N-1:0]     cmd_mask,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [GAP_W-1:0] cmd_gap,
  input  logic             abort,
  output logic [N-1:0]     q,
  output logic [N-1:0]     nq,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] remaining
);

  state_t             state, state_nx;
  logic [N-1:0]       mask_r;
  logic [GAP_W-1:0]   gap_r, gap_cnt, gap_cnt_nx;
  logic [CNT_W-1:0]   rem_nx;
  logic               pulse_en;
  logic               accept;

  always_comb begin
    state_nx   = state;
    rem_nx     = remaining;
    gap_cnt_nx = gap_cnt;
    pulse_en   = 1'b0;
    accept     = 1'b0;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          accept   = 1'b1;
          rem_nx   = cmd_count;
          state_nx = (cmd_count == '0) ? S_DONE : S_PULSE;
        end
      end
      S_PULSE: begin
        // abort wins over the toggle of this cycle
        if (abort) begin
          rem_nx   = '0;
          state_nx = S_DONE;
        end else begin
          pulse_en = 1'b1;
          rem_nx   = remaining - CNT_W'(1);
          if (remaining == CNT_W'(1)) begin
            state_nx = S_DONE;
          end else if (gap_r == '0) begin
            state_nx = S_PULSE;
          end else begin
            state_nx   = S_GAP;
            gap_cnt_nx = gap_r;
          end
        end
      end
      S_GAP: begin
        if (abort) begin
          rem_nx   = '0;
          state_nx = S_DONE;
        end else begin
          gap_cnt_nx = gap_cnt - GAP_W'(1);
          if (gap_cnt == GAP_W'(1)) begin
            state_nx = S_PULSE;
          end
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      remaining <= '0;
      gap_cnt   <= '0;
      mask_r    <= '0;
      gap_r     <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      remaining <= rem_nx;
      gap_cnt   <= gap_cnt_nx;
      done      <= (state_nx == S_DONE);
      if (accept) begin
        mask_r <= cmd_mask;
        gap_r  <= cmd_gap;
      end
    end
  end

  assign busy      = (state == S_PULSE) || (state == S_GAP);
  assign cmd_ready = (state == S_IDLE);

  for (genvar i = 0; i < N; i++) begin : g_cell
    ttrig_cell u_cell (
      .clk (clk),
      .rst (rst),
      .en  (pulse_en & mask_r[i]),
      .q   (q[i]),
      .nq  (nq[i])
    );
  end

endmodule

// File: tb/tb_ttrig_bank_seq.sv
// tb/tb_ttrig_bank_seq.sv - randomized self-checking bench for ttrig_bank_seq against a timing-rule model
module tb_ttrig_bank_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_mask;
  logic [7:0] cmd_count;
  logic [3:0] cmd_gap;
  logic       abort;
  logic [7:0] q;
  logic [7:0] nq;
  logic       busy;
  logic       done;
  logic [7:0] remaining;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] q_model  = 8'h00;

  ttrig_bank_seq #(.N(8), .CNT_W(8), .GAP_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_mask  (cmd_mask),
    .cmd_count (cmd_count),
    .cmd_gap   (cmd_gap),
    .abort     (abort),
    .q         (q),
    .nq        (nq),
    .busy      (busy),
    .done      (done),
    .remaining (remaining)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // pulses issued at edges E1..E(tl) after accept at E0
  function automatic int pulses(input int cnt, input int gp, input int tl);
    int n;
    if (cnt == 0 || tl < 1) return 0;
    n = (tl - 1) / (gp + 1) + 1;
    return (n > cnt) ? cnt : n;
  endfunction

  // ab: busy-cycle index (relative to accept) in which abort is held, -1 for none
  task automatic run_cmd(input logic [7:0] m, input int cnt, input int gp, input int ab);
    int         lfull, lend, p, tl;
    logic [7:0] q0, qe;
    lfull = (cnt == 0) ? 0 : 1 + (cnt - 1) * (gp + 1);
    lend  = (ab >= 0 && ab < lfull) ? ab + 1 : lfull;
    q0    = q_model;
    qe    = q0;
    @(negedge clk);
    check("ready_pre", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_mask  = m;
    cmd_count = cnt[7:0];
    cmd_gap   = gp[3:0];
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_mask  = 8'($urandom);
    cmd_count = 8'($urandom);
    cmd_gap   = 4'($urandom);
    for (int t = 0; t <= lend + 1; t++) begin
      tl = (ab >= 0 && ab < t) ? ab : t;
      p  = pulses(cnt, gp, tl);
      qe = p[0] ? (q0 ^ m) : q0;
      check("q", {24'd0, q}, {24'd0, qe});
      check("nq", {24'd0, nq}, {24'd0, ~qe});
      check("busy", {31'd0, busy}, {31'd0, (t < lend)});
      check("done", {31'd0, done}, {31'd0, (t == lend)});
      check("ready", {31'd0, cmd_ready}, {31'd0, (t > lend)});
      check("remaining", {24'd0, remaining}, (t >= lend) ? 32'd0 : 32'(cnt - p));
      abort = (t == ab);
      if (t <= lend) @(negedge clk);
    end
    abort   = 1'b0;
    q_model = qe;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int m, cnt, gp, ab, lfull;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_mask  = 8'h00;
    cmd_count = 8'h00;
    cmd_gap   = 4'h0;
    abort     = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_q", {24'd0, q}, 32'h00);
    check("rst_nq", {24'd0, nq}, 32'hFF);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_rem", {24'd0, remaining}, 32'd0);
    rst = 1'b0;

    run_cmd(8'h05, 3, 0, -1);
    check("basic_nq", {24'd0, nq}, 32'hFA);
    run_cmd(8'h80, 2, 2, -1);
    run_cmd(8'hFF, 0, 5, -1);
    run_cmd(8'h01, 10, 3, 1);
    check("abort_q", {24'd0, q}, {24'd0, q_model ^ 8'h00});
    run_cmd(8'h00, 4, 1, -1);

    // async reset during GAP of a running command
    @(negedge clk);
    cmd_valid = 1'b1; cmd_mask = 8'h01; cmd_count = 8'd5; cmd_gap = 4'd3;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_q", {24'd0, q}, 32'h00);
    check("arst_nq", {24'd0, nq}, 32'hFF);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_ready", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    q_model = 8'h00;
    repeat (6) begin
      @(negedge clk);
      check("post_rst_busy", {31'd0, busy}, 32'd0);
      check("post_rst_q", {24'd0, q}, 32'h00);
    end

    // back-to-back with cmd_valid held across two commands
    @(negedge clk);
    cmd_valid = 1'b1; cmd_mask = 8'h02; cmd_count = 8'd1; cmd_gap = 4'd0;
    @(negedge clk);
    cmd_mask = 8'h04;
    check("b2b_q1", {24'd0, q}, 32'h00);
    @(negedge clk);
    check("b2b_done1", {31'd0, done}, 32'd1);
    check("b2b_q2", {24'd0, q}, 32'h02);
    check("b2b_ready1", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    check("b2b_ready2", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("b2b_busy2", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("b2b_done2", {31'd0, done}, 32'd1);
    check("b2b_final", {24'd0, q}, 32'h06);
    q_model = 8'h06;

    run_cmd(8'hA5, 255, 0, -1);

    for (int i = 0; i < 40; i++) begin
      m     = int'($urandom_range(0, 255));
      cnt   = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 20));
      gp    = int'($urandom_range(0, 15));
      lfull = (cnt == 0) ? 0 : 1 + (cnt - 1) * (gp + 1);
      ab    = (lfull > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, lfull - 1)) : -1;
      run_cmd(m[7:0], cnt, gp, ab);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
